// File: rtl/hdmi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hdmi_pkg
//  Description : Shared constants, state encoding and the BCH serial step
//                used by the HDMI data island packet assembler.
//  Revision    : 1.0 - initial release
// ============================================================================
package hdmi_pkg;

    localparam int PACKET_CYCLES  = 32;
    localparam int HEADER_BITS    = 24;
    localparam int SUBPACKET_BITS = 56;
    localparam int SUBPACKETS     = 4;
    localparam int ECC_BITS       = 8;

    // Reflected BCH generator x^8+x^7+x^6+1
    localparam logic [7:0] BCH_POLY = 8'h83;

    localparam logic [7:0] PKT_TYPE_NULL = 8'h00;
    localparam logic [7:0] PKT_TYPE_ACR  = 8'h01;
    localparam logic [7:0] PKT_TYPE_AVI  = 8'h82;

    // NULL packet: HB0 = type 0, HB1 = HB2 = 0
    localparam logic [23:0] NULL_HEADER = {16'h0000, PKT_TYPE_NULL};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } pkt_state_t;

    // One bit-serial step of the reflected BCH parity register
    function automatic logic [7:0] bch_step(input logic [7:0] e,
                                            input logic       b,
                                            input logic [7:0] poly);
        logic [7:0] s;
        s = e >> 1;
        if (e[0] ^ b) begin
            s = s ^ poly;
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hdmi_ecc_serial.sv
`default_nettype none
// ============================================================================
//  Module      : hdmi_ecc_serial
//  Description : Registered BCH parity accumulator absorbing BITS_PER_CYCLE
//                bits per enabled cycle (bit 0 first). 'clear' restarts the
//                accumulation from zero; with 'enable' also high, the bits of
//                that same cycle are absorbed into the fresh register.
//  Revision    : 1.0 - initial release
// ============================================================================
module hdmi_ecc_serial
    import hdmi_pkg::*;
#(
    parameter int         BITS_PER_CYCLE = 1,
    parameter logic [7:0] ECC_POLY       = BCH_POLY
) (
    input  logic                      clk_pixel,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      enable,
    input  logic [BITS_PER_CYCLE-1:0] bits_in,
    output logic [ECC_BITS-1:0]       ecc
);

    logic [ECC_BITS-1:0] r_ecc;
    logic [ECC_BITS-1:0] w_ecc_next;

    // Next parity: seed (zero on clear) stepped through each incoming bit
    always_comb begin
        w_ecc_next = clear ? '0 : r_ecc;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            w_ecc_next = bch_step(w_ecc_next, bits_in[i], ECC_POLY);
        end
    end

    // Parity register: step when enabled, otherwise honour clear or hold
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_ecc <= '0;
        end else if (enable) begin
            r_ecc <= w_ecc_next;
        end else if (clear) begin
            r_ecc <= '0;
        end
    end

    assign ecc = r_ecc;

endmodule
`default_nettype wire

// File: rtl/hdmi_packet_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : hdmi_packet_assembler
//  Description : Serializes one HDMI data island packet (24-bit header plus
//                four 56-bit subpackets) into 32 per-pixel positions with
//                BCH parity appended; a NULL packet is sent when the source
//                offers nothing at packet_start.
//  Revision    : 1.0 - initial release
// ============================================================================
module hdmi_packet_assembler
    import hdmi_pkg::*;
#(
    parameter logic [7:0] ECC_POLY = BCH_POLY
) (
    input  logic                                 clk_pixel,
    input  logic                                 reset,
    input  logic                                 packet_start,
    input  logic                                 packet_valid,
    output logic                                 packet_ready,
    input  logic [HEADER_BITS-1:0]               header,
    input  logic [SUBPACKETS*SUBPACKET_BITS-1:0] subpacket,
    output logic                                 busy,
    output logic [8:0]                           packet_bits
);

    localparam int c_CNT_W       = $clog2(PACKET_CYCLES);
    localparam int c_LAST_POS    = PACKET_CYCLES - 1;
    localparam int c_SP_DATA_POS = SUBPACKET_BITS / 2;

    pkt_state_t                          r_state;
    pkt_state_t                          w_state_next;
    logic [c_CNT_W-1:0]                  r_count;
    logic [c_CNT_W-1:0]                  w_pos;
    logic                                w_at_last;
    logic                                w_capture;
    logic                                w_emit;
    logic [HEADER_BITS-1:0]              r_header;
    logic [HEADER_BITS-1:0]              w_src_header;
    logic [SUBPACKETS*SUBPACKET_BITS-1:0] r_subpacket;
    logic [SUBPACKETS*SUBPACKET_BITS-1:0] w_src_subpacket;
    logic                                w_hdr_data;
    logic                                w_sp_data;
    logic                                w_hdr_bit;
    logic [ECC_BITS-1:0]                 w_hdr_ecc;
    logic                                w_ch0;
    logic [SUBPACKETS-1:0]               w_ch1;
    logic [SUBPACKETS-1:0]               w_ch2;
    logic [8:0]                          w_bits_next;

    assign w_at_last = (r_count == c_CNT_W'(c_LAST_POS));
    assign busy      = (r_state == ST_SEND);

    // State register
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, capture decision and the combinational ready handshake
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        packet_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (packet_start) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_at_last) begin
                    if (packet_start) begin
                        w_capture = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        packet_ready = w_capture && packet_valid && !reset;
    end

    // The output register is loaded one cycle ahead: on a capture edge it
    // takes position 0 straight from the offered data, otherwise position
    // r_count+1 from the latched copy. The ECC accumulators follow the same
    // timing, so parity is complete exactly when its first bit is needed.
    assign w_src_header    = w_capture ? (packet_valid ? header : NULL_HEADER) : r_header;
    assign w_src_subpacket = w_capture ? (packet_valid ? subpacket : '0)       : r_subpacket;
    assign w_pos           = w_capture ? '0 : (r_count + 1'b1);
    assign w_emit          = w_capture || ((r_state == ST_SEND) && !w_at_last);
    assign w_hdr_data      = (w_pos < c_CNT_W'(HEADER_BITS));
    assign w_sp_data       = (w_pos < c_CNT_W'(c_SP_DATA_POS));

    assign w_hdr_bit = w_src_header[w_pos];

    hdmi_ecc_serial #(
        .BITS_PER_CYCLE (1),
        .ECC_POLY       (ECC_POLY)
    ) u_hdr_ecc (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .clear     (w_capture),
        .enable    (w_emit && w_hdr_data),
        .bits_in   (w_hdr_bit),
        .ecc       (w_hdr_ecc)
    );

    // Positions 24..31 carry header parity; 24 is a multiple of 8 so the
    // parity bit index is simply the low three bits of the position.
    assign w_ch0 = w_hdr_data ? w_hdr_bit : w_hdr_ecc[w_pos[2:0]];

    for (genvar gi = 0; gi < SUBPACKETS; gi++) begin : g_subpacket
        logic [SUBPACKET_BITS-1:0] w_word;
        logic [1:0]                w_pair;
        logic [1:0]                w_parity_pair;
        logic [ECC_BITS-1:0]       w_ecc;

        assign w_word = w_src_subpacket[SUBPACKET_BITS*gi +: SUBPACKET_BITS];
        assign w_pair = w_word[{w_pos, 1'b0} +: 2];

        hdmi_ecc_serial #(
            .BITS_PER_CYCLE (2),
            .ECC_POLY       (ECC_POLY)
        ) u_sp_ecc (
            .clk_pixel (clk_pixel),
            .reset     (reset),
            .clear     (w_capture),
            .enable    (w_emit && w_sp_data),
            .bits_in   (w_pair),
            .ecc       (w_ecc)
        );

        // Positions 28..31 carry parity pairs; 28 is a multiple of 4 so the
        // pair index is the low two bits of the position.
        assign w_parity_pair = w_ecc[{w_pos[1:0], 1'b0} +: 2];
        assign w_ch1[gi]     = w_sp_data ? w_pair[0] : w_parity_pair[0];
        assign w_ch2[gi]     = w_sp_data ? w_pair[1] : w_parity_pair[1];
    end

    assign w_bits_next = {w_ch2, w_ch1, w_ch0};

    // Packet data latch, position counter and registered output
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_count     <= '0;
            r_header    <= '0;
            r_subpacket <= '0;
            packet_bits <= '0;
        end else begin
            if (w_capture) begin
                r_count     <= '0;
                r_header    <= w_src_header;
                r_subpacket <= w_src_subpacket;
            end else if (w_emit) begin
                r_count <= r_count + 1'b1;
            end
            packet_bits <= w_emit ? w_bits_next : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hdmi_packet_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hdmi_packet_assembler
//  Description : Directed self-checking bench for hdmi_packet_assembler.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hdmi_packet_assembler;
    import hdmi_pkg::*;

    logic         clk_pixel = 1'b0;
    logic         reset;
    logic         packet_start;
    logic         packet_valid;
    logic         packet_ready;
    logic [23:0]  header;
    logic [223:0] subpacket;
    logic         busy;
    logic [8:0]   packet_bits;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_pixel = ~clk_pixel;

    hdmi_packet_assembler #(.ECC_POLY(8'h83)) dut (
        .clk_pixel    (clk_pixel),
        .reset        (reset),
        .packet_start (packet_start),
        .packet_valid (packet_valid),
        .packet_ready (packet_ready),
        .header       (header),
        .subpacket    (subpacket),
        .busy         (busy),
        .packet_bits  (packet_bits)
    );

    // Reference parity step: e = (e[0]^b) ? (e>>1)^0x83 : e>>1
    function automatic logic [7:0] ecc_step(input logic [7:0] e, input logic b);
        return (e[0] ^ b) ? ((e >> 1) ^ 8'h83) : (e >> 1);
    endfunction

    // Reference value of packet_bits at position k
    function automatic logic [8:0] exp_bits(input logic [23:0] h, input logic [223:0] sp, input int k);
        logic [7:0]  he;
        logic [7:0]  se;
        logic [55:0] s;
        logic [3:0]  c1;
        logic [3:0]  c2;
        logic        c0;
        he = '0;
        for (int j = 0; j < 24; j++) he = ecc_step(he, h[j]);
        c0 = (k < 24) ? h[k] : he[k-24];
        for (int i = 0; i < 4; i++) begin
            s  = sp[56*i +: 56];
            se = '0;
            for (int j = 0; j < 56; j++) se = ecc_step(se, s[j]);
            if (k < 28) begin
                c1[i] = s[2*k];
                c2[i] = s[2*k+1];
            end else begin
                c1[i] = se[2*(k-28)];
                c2[i] = se[2*(k-28)+1];
            end
        end
        return {c2, c1, c0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer a packet in the current cycle and check the handshake
    task automatic capture(input string tag, input logic [23:0] h, input logic [223:0] sp, input logic valid);
        packet_start = 1'b1;
        packet_valid = valid;
        header       = h;
        subpacket    = sp;
        @(negedge clk_pixel);
        check($sformatf("%s ready", tag), {31'b0, packet_ready}, {31'b0, valid});
        @(posedge clk_pixel); #1;
        packet_start = 1'b0;
        packet_valid = 1'b0;
        header       = '1;
        subpacket    = '1;
    endtask

    // Check positions 0..last_k; at position inj_k offer packet (ih, isp)
    task automatic emit(input string tag, input logic [23:0] h, input logic [223:0] sp,
                        input int inj_k, input logic [23:0] ih, input logic [223:0] isp,
                        input int last_k);
        for (int k = 0; k <= last_k; k++) begin
            if (k == inj_k) begin
                packet_start = 1'b1;
                packet_valid = 1'b1;
                header       = ih;
                subpacket    = isp;
            end
            @(negedge clk_pixel);
            check($sformatf("%s k=%0d bits", tag, k), {23'b0, packet_bits}, {23'b0, exp_bits(h, sp, k)});
            check($sformatf("%s k=%0d busy", tag, k), {31'b0, busy}, 32'd1);
            check($sformatf("%s k=%0d ready", tag, k), {31'b0, packet_ready},
                  {31'b0, (k == inj_k) && (k == 31)});
            @(posedge clk_pixel); #1;
            if (k == inj_k) begin
                packet_start = 1'b0;
                packet_valid = 1'b0;
                header       = '1;
                subpacket    = '1;
            end
        end
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk_pixel);
        check($sformatf("%s idle busy", tag), {31'b0, busy}, 32'd0);
        check($sformatf("%s idle bits", tag), {23'b0, packet_bits}, 32'd0);
        check($sformatf("%s idle ready", tag), {31'b0, packet_ready}, 32'd0);
        @(posedge clk_pixel); #1;
    endtask

    logic [23:0]  h_a, h_b, h_c;
    logic [223:0] sp_a, sp_b, sp_c;

    initial begin
        reset        = 1'b1;
        packet_start = 1'b0;
        packet_valid = 1'b0;
        header       = '0;
        subpacket    = '0;
        h_a  = {8'h0D, 8'h02, PKT_TYPE_AVI};
        sp_a = {56'h0123456789ABCD, 56'hFEDCBA98765432, 56'h00FF00FF00FF00, 56'h8000000000003C};
        h_b  = {8'h00, 8'h00, PKT_TYPE_ACR};
        sp_b = {56'h11111111111111, 56'h2468ACE0246800, 56'hFFFFFFFFFFFFFF, 56'h0000000000A5A5};
        h_c  = {8'hC3, 8'h5A, PKT_TYPE_ACR};
        sp_c = {56'h00000000000001, 56'h80000000000000, 56'h123456789ABCDE, 56'h0F0F0F0F0F0F0F};

        // Reset state
        repeat (3) @(posedge clk_pixel);
        #1;
        @(negedge clk_pixel);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset bits", {23'b0, packet_bits}, 32'd0);
        check("reset ready", {31'b0, packet_ready}, 32'd0);
        @(posedge clk_pixel); #1;
        reset = 1'b0;
        idle_check("post_reset");

        // 1: NULL packet (offered data must be ignored when not valid)
        capture("null", 24'hABCDEF, sp_a, 1'b0);
        emit("null", 24'h0, 224'h0, -1, '0, '0, 31);
        idle_check("null");

        // 2: single header bit set
        capture("hdr1", 24'h000001, 224'h0, 1'b1);
        emit("hdr1", 24'h000001, 224'h0, -1, '0, '0, 31);
        idle_check("hdr1");

        // 3: subpacket 0 bit 0 set
        capture("sp1", 24'h0, 224'h1, 1'b1);
        emit("sp1", 24'h0, 224'h1, -1, '0, '0, 31);
        idle_check("sp1");

        // 4: back-to-back packets with no gap
        capture("b2b_a", h_a, sp_a, 1'b1);
        emit("b2b_a", h_a, sp_a, 31, h_b, sp_b, 31);
        emit("b2b_b", h_b, sp_b, -1, '0, '0, 31);
        idle_check("b2b");

        // 5: packet_start mid-packet is ignored
        capture("mid", h_b, sp_b, 1'b1);
        emit("mid", h_b, sp_b, 10, 24'h5A5A5A, sp_c, 31);
        idle_check("mid");

        // 6: reset at position 15 aborts, then a fresh packet is correct
        capture("rst", h_a, sp_a, 1'b1);
        emit("rst", h_a, sp_a, -1, '0, '0, 14);
        reset = 1'b1;
        @(posedge clk_pixel); #1;
        reset = 1'b0;
        idle_check("rst_abort");
        capture("rst_new", h_c, sp_c, 1'b1);
        emit("rst_new", h_c, sp_c, -1, '0, '0, 31);
        idle_check("rst_new");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
